// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, DBITS data bits LSB-first, optional even parity, SBITS stop bits.
// Define UART_TX_PARITY_EN to insert the parity bit between data and stop bits.
module uart_transmitter #(
   parameter int unsigned DBITS    = 8,
   parameter int unsigned SBITS    = 1,
   parameter int unsigned BAUD_DIV = 10416
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             tx_start,
   input  logic [DBITS-1:0] data_in,
   output logic             tx,
   output logic             tx_busy,
   output logic             tx_done
);

   localparam int unsigned CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
   localparam int unsigned BW = (DBITS > 2) ? $clog2(DBITS) : 1;

   localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DBITS - 1);
   localparam logic          STOP_LAST = 1'(SBITS - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd4;
`endif

   logic [2:0]       state_q, state_d;
   logic [CW-1:0]    baud_q, baud_d;
   logic [BW-1:0]    bit_q, bit_d;
   logic             stop_q, stop_d;
   logic [DBITS-1:0] shift_q, shift_d;
   logic             tx_q, tx_d;
   logic             done_q, done_d;
   logic             baud_end;
`ifdef UART_TX_PARITY_EN
   logic             parity_q, parity_d;
`endif

   assign baud_end = (baud_q == BAUD_LAST);

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      stop_d  = stop_q;
      shift_d = shift_q;
      done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d = parity_q;
`endif

      if (state_q != S_IDLE) begin
         baud_d = baud_end ? '0 : baud_q + 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (tx_start) begin
               state_d = S_START;
               shift_d = data_in;
               baud_d  = '0;
`ifdef UART_TX_PARITY_EN
               parity_d = ^data_in;
`endif
            end
         end
         S_START: begin
            if (baud_end) begin
               state_d = S_DATA;
               bit_d   = '0;
            end
         end
         S_DATA: begin
            if (baud_end) begin
               shift_d = shift_q >> 1;
               if (bit_q == BIT_LAST) begin
                  bit_d  = '0;
                  stop_d = 1'b0;
`ifdef UART_TX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (baud_end) begin
               state_d = S_STOP;
               stop_d  = 1'b0;
            end
         end
`endif
         S_STOP: begin
            if (baud_end) begin
               if (stop_q == STOP_LAST) begin
                  state_d = S_IDLE;
                  stop_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  stop_d = stop_q + 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // tx is registered, so it is derived from the state being entered
      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         S_PARITY: tx_d = parity_q;
`endif
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         stop_q  <= 1'b0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         stop_q  <= stop_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
      end
   end

`ifdef UART_TX_PARITY_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         parity_q <= 1'b0;
      end else begin
         parity_q <= parity_d;
      end
   end
`endif

   assign tx      = tx_q;
   assign tx_busy = (state_q != S_IDLE);
   assign tx_done = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: per-cycle frame model plus a loopback receiver model.
module tb_uart_transmitter;

   localparam int unsigned DBITS    = 8;
   localparam int unsigned SBITS    = 1;
   localparam int unsigned BAUD_DIV = 16;
`ifdef UART_TX_PARITY_EN
   localparam int unsigned PBITS = 1;
`else
   localparam int unsigned PBITS = 0;
`endif
   localparam int unsigned NB = 1 + DBITS + PBITS + SBITS;

   logic             clock;
   logic             reset;
   logic             tx_start;
   logic [DBITS-1:0] data_in;
   logic             tx;
   logic             tx_busy;
   logic             tx_done;

   int n_checks = 0;
   int n_fail   = 0;

   logic [DBITS-1:0] rx_q[$];

   uart_transmitter #(
      .DBITS   (DBITS),
      .SBITS   (SBITS),
      .BAUD_DIV(BAUD_DIV)
   ) dut (
      .clock   (clock),
      .reset   (reset),
      .tx_start(tx_start),
      .data_in (data_in),
      .tx      (tx),
      .tx_busy (tx_busy),
      .tx_done (tx_done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Expected line level for bit slot k of a frame carrying d
   function automatic logic frame_bit(input logic [DBITS-1:0] d, input int k);
      if (k == 0) return 1'b0;
      if (k <= int'(DBITS)) return d[k-1];
      if (PBITS == 1 && k == int'(DBITS) + 1) return ^d;
      return 1'b1;
   endfunction

   // Behavioural receiver: samples mid-bit on negedges
   always begin
      logic [DBITS-1:0] r;
      @(negedge tx);
      repeat (BAUD_DIV / 2) @(negedge clock);
      if (tx == 1'b0) begin
         for (int i = 0; i < int'(DBITS); i++) begin
            repeat (BAUD_DIV) @(negedge clock);
            r[i] = tx;
         end
         repeat (BAUD_DIV * (PBITS + 1)) @(negedge clock);
         if (tx == 1'b1) rx_q.push_back(r);
      end
   end

   // Called at a negedge: accept happens on the following posedge
   task automatic start(input logic [DBITS-1:0] d);
      tx_start = 1'b1;
      data_in  = d;
      @(posedge clock);
      #1;
      tx_start = 1'b0;
      data_in  = DBITS'($urandom);
   endtask

   task automatic body(input logic [DBITS-1:0] d, input int inject);
      for (int c = 0; c < int'(NB * BAUD_DIV); c++) begin
         @(negedge clock);
         check("tx", {31'd0, tx}, {31'd0, frame_bit(d, c / int'(BAUD_DIV))});
         check("busy", {31'd0, tx_busy}, 32'd1);
         check("done_early", {31'd0, tx_done}, 32'd0);
         tx_start = (c == inject);
         data_in  = (c == inject) ? {DBITS{1'b1}} : DBITS'($urandom);
      end
   endtask

   task automatic frame_end();
      @(negedge clock);
      check("done", {31'd0, tx_done}, 32'd1);
      check("busy_at_done", {31'd0, tx_busy}, 32'd0);
      check("tx_at_done", {31'd0, tx}, 32'd1);
   endtask

   task automatic idle(input int n, input string tag);
      for (int c = 0; c < n; c++) begin
         @(negedge clock);
         check({tag, "_tx"}, {31'd0, tx}, 32'd1);
         check({tag, "_busy"}, {31'd0, tx_busy}, 32'd0);
         check({tag, "_done"}, {31'd0, tx_done}, 32'd0);
      end
   endtask

   initial begin
      logic [DBITS-1:0] d;
      reset    = 1'b0;
      tx_start = 1'b0;
      data_in  = '0;

      // Reset held with tx_start toggling
      for (int c = 0; c < 10; c++) begin
         @(negedge clock);
         tx_start = ~tx_start;
         data_in  = DBITS'($urandom);
         #1;
         check("rst_tx", {31'd0, tx}, 32'd1);
         check("rst_busy", {31'd0, tx_busy}, 32'd0);
         check("rst_done", {31'd0, tx_done}, 32'd0);
      end
      @(negedge clock);
      tx_start = 1'b0;
      reset    = 1'b1;
      idle(5, "rel");

      // Single frame 0x55
      @(negedge clock);
      start(8'h55);
      body(8'h55, -1);
      frame_end();
      idle(3, "post55");

      // Back-to-back 0xA3 then 0x0F, loopback decoded
      rx_q.delete();
      start(8'hA3);
      body(8'hA3, -1);
      frame_end();
      start(8'h0F);
      body(8'h0F, -1);
      frame_end();
      check("rx_count", rx_q.size(), 32'd2);
      if (rx_q.size() == 2) begin
         check("rx_byte0", {24'd0, rx_q[0]}, 32'hA3);
         check("rx_byte1", {24'd0, rx_q[1]}, 32'h0F);
      end
      idle(3, "postb2b");

      // Busy rejection: tx_start with 0xFF mid-frame of 0x00
      start(8'h00);
      body(8'h00, 39);
      frame_end();
      idle(2 * NB * BAUD_DIV, "reject");

      // Random frames, random back-to-back or gaps
      for (int i = 0; i < 6; i++) begin
         d = DBITS'($urandom);
         start(d);
         body(d, -1);
         frame_end();
         if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 20), "gap");
      end
      idle(2, "prereset");

      // Reset mid-frame during data bit 3
      d = DBITS'($urandom);
      start(d);
      for (int c = 0; c < int'(4 * BAUD_DIV) + 5; c++) begin
         @(negedge clock);
         check("pre_rst_tx", {31'd0, tx}, {31'd0, frame_bit(d, c / int'(BAUD_DIV))});
      end
      #2 reset = 1'b0;
      #1;
      check("abort_tx", {31'd0, tx}, 32'd1);
      check("abort_busy", {31'd0, tx_busy}, 32'd0);
      check("abort_done", {31'd0, tx_done}, 32'd0);
      idle(3, "inrst");
      reset = 1'b1;
      idle(NB * BAUD_DIV + 5, "aborted");
      start(8'h81);
      body(8'h81, -1);
      frame_end();

`ifdef UART_TX_PARITY_EN
      // Parity frames: 0x07 -> parity 1, 0x03 -> parity 0
      check("par07_model", {31'd0, frame_bit(8'h07, DBITS + 1)}, 32'd1);
      start(8'h07);
      body(8'h07, -1);
      frame_end();
      start(8'h03);
      body(8'h03, -1);
      frame_end();
`endif
      idle(3, "final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- Serial UART transmitter. Pairs with the existing 8N1 UART receiver and uses the same baud divisor (10416 clocks/bit).
- Takes a parallel byte with a single-cycle start handshake and serialises it LSB-first on `tx`: start bit, DBITS data bits, then SBITS stop bits.
- Sits in the top level beside the receiver. Drives the board TX line, or is looped back to `rx` for self-test.

Parameters:
- DBITS, 8, number of data bits per frame (5..9).
- SBITS, 1, number of stop bits (1 or 2).
- BAUD_DIV, 10416, clock cycles per bit; must be >= 2.

Ports:
- clock  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted); deassertion is synchronous to clock.
- tx_start  input  1  request to send; sampled every cycle.
- data_in  input  DBITS  byte to send; sampled only on an accepted tx_start.
- tx  output  1  serial line; idles high; registered output.
- tx_busy  output  1  high while a frame is in progress.
- tx_done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (reset=0, immediate, no clock needed):
  - state=IDLE, tx=1, tx_busy=0, tx_done=0.
  - Baud counter, bit counter and shift register all cleared.
  - Reset mid-frame aborts the frame and returns tx to 1 immediately; no tx_done is produced.
- FSM states: IDLE, START, DATA, STOP (plus PARITY under the option below).
- IDLE:
  - tx=1. Accept when tx_start=1: latch data_in into the shift register, clear the baud counter, go to START.
  - tx_start while busy (any non-IDLE state) is ignored and not queued.
- Bit timing:
  - The baud counter runs 0..BAUD_DIV-1 in every non-IDLE state.
  - Each bit is held on tx for exactly BAUD_DIV cycles.
  - The state/bit advances on the cycle where the counter equals BAUD_DIV-1; the counter then wraps to 0.
- START: tx=0 for one bit time, then go to DATA with bit_cnt=0.
- DATA:
  - tx = shift_reg[0]; the shift register shifts right at each bit end.
  - After bit DBITS-1 (bit_cnt==DBITS-1 at the bit end), go to STOP.
- STOP: tx=1 for SBITS bit times, tracked by a stop-bit counter, then go to IDLE.
- Latency:
  - tx falls on the first rising edge after the accept cycle.
  - The frame lasts exactly (1+DBITS+SBITS)*BAUD_DIV cycles from that edge.
- tx_busy: equals (state != IDLE), so it rises the cycle after accept.
- tx_done:
  - Registered 1-cycle pulse in the first IDLE cycle after the last stop bit.
  - tx_busy=0 in that same cycle.
  - A tx_start in that cycle is accepted, giving back-to-back frames with no extra idle gap.
- Input sampling: data_in changes after accept have no effect on the frame in flight.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, lasting one bit time.
  - tx = even parity (XOR of all DBITS latched data bits).
  - Frame length becomes (2+DBITS+SBITS)*BAUD_DIV.
- Not defined: no PARITY state and no parity logic; DATA goes directly to STOP.

Test Plan:
- Reset: hold reset=0 with tx_start=1 toggling -> tx=1, tx_busy=0, tx_done=0 throughout. Release with tx_start=0 -> outputs unchanged.
- Single frame: BAUD_DIV=16, data_in=0x55, 1-cycle tx_start.
  - tx sequence per 16-cycle bit: 0, 1,0,1,0,1,0,1,0, 1.
  - tx_busy high for 160 cycles.
  - tx_done pulses at cycle 161 after accept.
- Back-to-back: BAUD_DIV=16, send 0xA3, then assert tx_start with 0x0F in the tx_done cycle.
  - Second start bit begins immediately after the first stop bit.
  - A loopback into the receiver (run at matching divisor) yields 0xA3 then 0x0F.
- Busy rejection: pulse tx_start with 0xFF at cycle 40 of a 0x00 frame -> frame stays 0x00; no second frame follows.
- Reset mid-frame: assert reset during DATA bit 3 -> tx=1 the same cycle; no tx_done. A new 0x81 frame after release transmits correctly.
- Parity (UART_TX_PARITY_EN, BAUD_DIV=16):
  - 0x07 -> parity bit=1, frame=176 cycles.
  - 0x03 -> parity bit=0.
